// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg
//   Shared definitions for the serial loader: FSM state encoding, default
//   parameter values and the width of the shared bit/gap counter.
package serial_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_LSB_FIRST  = 1;
  localparam int DEF_GAP_CYCLES = 1;

  // Wide enough for WIDTH-1 up to 31 and GAP_CYCLES-1 up to 14.
  localparam int CNT_W = 5;

endpackage

// File: rtl/serial_loader_bit_counter.sv
// bit_counter
//   Loadable up-counter with a terminal-count flag. The counter stops at the
//   terminal value (no wrap); a load takes priority over counting.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   load          load count with load_value this cycle
//   load_value    value loaded on load
//   enable        count up by one (ignored while tc is high)
//   terminal      value at which tc asserts and counting stops
//   count         current count
//   tc            count == terminal
module bit_counter
  import serial_loader_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == terminal);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !tc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serial_loader.sv
// serial_loader
//   Parallel-to-serial converter. A word accepted in IDLE is captured and
//   shifted out one bit per cycle over WIDTH cycles (SHIFT), followed by
//   GAP_CYCLES idle cycles (GAP), then the block returns to IDLE.
//
//   Handshake: a word is accepted on a rising edge where load_valid and
//   load_ready are both high. load_ready depends only on the state (high in
//   IDLE); load_valid while busy is ignored. The first bit appears in the
//   cycle right after the accepting edge.
//
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   data_in       parallel word to serialize
//   load_valid    data_in valid this cycle
//   load_ready    block can accept a word this cycle
//   shift_out     serial bit (0 whenever bit_valid is 0), registered
//   bit_valid     shift_out carries a data bit, registered
//   frame_start   first bit of a word, registered
//   word_done     last bit of a word, registered
//   busy          state is not IDLE
//   state_dbg     current FSM state encoding (debug)
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LSB_FIRST  = DEF_LSB_FIRST,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             shift_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             word_done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
  // Count value during the second-to-last bit; word_done is registered there.
  localparam logic [CNT_W-1:0] SHIFT_PREV = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] GAP_LAST   =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state, state_next;
  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_terminal;
  logic [CNT_W-1:0] count;
  logic             cnt_tc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;

  // Bit that goes out first from a given register image.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  assign shreg_next = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

  // One counter serves both phases; it is reloaded to 0 on every phase entry.
  bit_counter #(.W(CNT_W)) u_bit_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value ('0),
    .enable     (cnt_en),
    .terminal   (cnt_terminal),
    .count      (count),
    .tc         (cnt_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_terminal = SHIFT_LAST;
    case (state)
      IDLE: begin
        if (load_valid) begin
          accept     = 1'b1;
          cnt_load   = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cnt_load   = 1'b1;
          state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        cnt_terminal = GAP_LAST;
        cnt_en       = 1'b1;
        if (cnt_tc) begin
          cnt_load   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output bits are computed from the next register image so that every
  // serial output comes straight from a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      shift_out   <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      word_done   <= 1'b0;
    end else begin
      frame_start <= accept;
      if (accept) begin
        shreg     <= data_in;
        shift_out <= first_bit(data_in);
        bit_valid <= 1'b1;
        word_done <= 1'b0;
      end else if (state == SHIFT && !cnt_tc) begin
        shreg     <= shreg_next;
        shift_out <= first_bit(shreg_next);
        bit_valid <= 1'b1;
        word_done <= (count == SHIFT_PREV);
      end else begin
        shift_out <= 1'b0;
        bit_valid <= 1'b0;
        word_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader
//   Two instances: dut0 (LSB first, one gap cycle) and dut1 (MSB first, no
//   gap). Expected streams are derived from the word value and the
//   parameters; inputs are driven and outputs sampled on the falling edge.
module tb_serial_loader;

  localparam int W     = 8;
  localparam int LSB0  = 1;
  localparam int GAP0  = 1;
  localparam int LSB1  = 0;
  localparam int GAP1  = 0;

  logic         clock;
  logic         reset;
  logic [W-1:0] data_in     [2];
  logic         load_valid  [2];
  logic         load_ready  [2];
  logic         shift_out   [2];
  logic         bit_valid   [2];
  logic         frame_start [2];
  logic         word_done   [2];
  logic         busy        [2];
  logic [1:0]   state_dbg   [2];
  logic [3:0]   chain       [2];

  int tests = 0;
  int fails = 0;

  serial_loader #(.WIDTH(W), .LSB_FIRST(LSB0), .GAP_CYCLES(GAP0)) dut0 (
    .clock(clock), .reset(reset), .data_in(data_in[0]), .load_valid(load_valid[0]),
    .load_ready(load_ready[0]), .shift_out(shift_out[0]), .bit_valid(bit_valid[0]),
    .frame_start(frame_start[0]), .word_done(word_done[0]), .busy(busy[0]),
    .state_dbg(state_dbg[0])
  );

  serial_loader #(.WIDTH(W), .LSB_FIRST(LSB1), .GAP_CYCLES(GAP1)) dut1 (
    .clock(clock), .reset(reset), .data_in(data_in[1]), .load_valid(load_valid[1]),
    .load_ready(load_ready[1]), .shift_out(shift_out[1]), .bit_valid(bit_valid[1]),
    .frame_start(frame_start[1]), .word_done(word_done[1]), .busy(busy[1]),
    .state_dbg(state_dbg[1])
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream 4-bit shift registers fed by each serial stream.
  always @(posedge clock) begin
    chain[0] <= {chain[0][2:0], shift_out[0]};
    chain[1] <= {chain[1][2:0], shift_out[1]};
  end

  // ---------------- reference model helpers ----------------
  function automatic int gap_of(input int sel);
    return (sel == 0) ? GAP0 : GAP1;
  endfunction

  // Bit transmitted in position i of a word.
  function automatic logic model_bit(input int sel, input logic [W-1:0] w, input int i);
    int lsb;
    lsb = (sel == 0) ? LSB0 : LSB1;
    return ((w >> ((lsb != 0) ? i : (W - 1 - i))) & 1) != 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int sel, input logic exp_busy);
    chk("idle_busy",  busy[sel],        exp_busy);
    chk("idle_ready", load_ready[sel],  !exp_busy);
    chk("idle_bv",    bit_valid[sel],   1'b0);
    chk("idle_so",    shift_out[sel],   1'b0);
    chk("idle_fs",    frame_start[sel], 1'b0);
    chk("idle_wd",    word_done[sel],   1'b0);
  endtask

  // Called at the falling edge of an IDLE cycle. Sends word w and checks the
  // full frame plus gap, ending at the falling edge of the next IDLE cycle.
  // With hold=1, load_valid stays high throughout (caller supplies the next
  // word or drops load_valid); otherwise load_valid toggles randomly while
  // busy and must be ignored.
  task automatic send_word(input int sel, input logic [W-1:0] w, input bit hold);
    int gap;
    int last;
    int k;
    gap  = gap_of(sel);
    last = W + gap - 1;
    k    = 0;
    chk_idle(sel, 1'b0);
    data_in[sel]    = w;
    load_valid[sel] = 1'b1;
    @(negedge clock);
    for (int i = 0; i < W; i++) begin
      chk("bit",    shift_out[sel],   model_bit(sel, w, i));
      chk("bv",     bit_valid[sel],   1'b1);
      chk("fs",     frame_start[sel], (i == 0));
      chk("wd",     word_done[sel],   (i == W - 1));
      chk("busy",   busy[sel],        1'b1);
      chk("ready",  load_ready[sel],  1'b0);
      if (i >= 4) chk("chain", chain[sel][3], model_bit(sel, w, i - 4));
      data_in[sel]    = (i == 0) ? 8'hFF : W'($urandom);
      load_valid[sel] = (k == last) ? hold : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      k++;
      @(negedge clock);
    end
    for (int g = 0; g < gap; g++) begin
      chk_idle(sel, 1'b1);
      load_valid[sel] = (k == last) ? hold : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      k++;
      @(negedge clock);
    end
  endtask

  // Holds load_valid high across two words and measures the distance between
  // the two frame_start pulses. Starts and ends at an IDLE falling edge.
  task automatic measure_period(input int sel, input logic [W-1:0] w0,
                                input logic [W-1:0] w1, input int exp_period);
    int n;
    int n1;
    int n2;
    bit found1;
    bit found2;
    n = 0; n1 = 0; n2 = 0; found1 = 0; found2 = 0;
    data_in[sel]    = w0;
    load_valid[sel] = 1'b1;
    for (int c = 0; c < 40 && !found2; c++) begin
      @(negedge clock);
      n++;
      if (bit_valid[sel] == 1'b0) chk("gap_so_zero", shift_out[sel], 1'b0);
      if (frame_start[sel]) begin
        if (!found1) begin
          found1 = 1; n1 = n; data_in[sel] = w1;
        end else begin
          found2 = 1; n2 = n; load_valid[sel] = 1'b0;
        end
      end
    end
    load_valid[sel] = 1'b0;
    chk("period_fs_seen", {30'd0, found1, found2}, 32'd3);
    chk("period", n2 - n1, exp_period);
    for (int c = 0; c < W + gap_of(sel); c++) @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] w;
    int sel;
    reset         = 1'b1;
    data_in[0]    = '0;
    data_in[1]    = '0;
    load_valid[0] = 1'b0;
    load_valid[1] = 1'b0;

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    chk_idle(0, 1'b0);
    chk_idle(1, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Directed words.
    send_word(0, 8'hA5, 1'b0);
    send_word(1, 8'h80, 1'b0);
    send_word(0, 8'h01, 1'b0);
    send_word(1, 8'h3C, 1'b0);

    // Word period with load_valid held high.
    measure_period(0, 8'h01, 8'h02, W + GAP0 + 1);
    measure_period(1, 8'h01, 8'h02, W + GAP1 + 1);

    // Held-valid back-to-back streams.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 4; n++) send_word(s, W'($urandom), 1'b1);
      load_valid[s] = 1'b0;
    end

    // Randomized words with random idle spacing.
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 1);
      w   = W'($urandom);
      send_word(sel, w, 1'b0);
      for (int c = $urandom_range(0, 3); c > 0; c--) begin
        chk_idle(sel, 1'b0);
        @(negedge clock);
      end
    end

    // Asynchronous reset in the middle of a frame.
    data_in[0]    = 8'hFF;
    load_valid[0] = 1'b1;
    @(negedge clock);
    load_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clock);
    chk("pre_rst_bit", shift_out[0], 1'b1);
    chk("pre_rst_bv",  bit_valid[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_idle(0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_wd",    word_done[0],  1'b0);
      chk("rst_ready", load_ready[0], 1'b1);
    end
    reset = 1'b0;
    @(negedge clock);
    send_word(0, 8'h0F, 1'b0);
    send_word(1, 8'h0F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
